// File: rtl/ecc_enc_stream.sv
// Streaming extended-Hamming (SEC-DED) encoder with valid/ready handshake,
// per-word code selection, optional error injection and a saturating word counter.
module ecc_enc_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int AMBA_WORD  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] info,
  input  logic [AMBA_WORD-1:0]  cw_mode,
  input  logic [DATA_WIDTH-1:0] err_mask,
  input  logic                  err_inj,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] codeword,
  output logic [1:0]            out_mode,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [3:0]  M4_P0  = 4'b1011;
  localparam logic [3:0]  M4_P1  = 4'b1101;
  localparam logic [3:0]  M4_P2  = 4'b1110;
  localparam logic [10:0] M11_P0 = 11'b10101011011;
  localparam logic [10:0] M11_P1 = 11'b11001101101;
  localparam logic [10:0] M11_P2 = 11'b11110001110;
  localparam logic [10:0] M11_P3 = 11'b11111110000;
  localparam logic [25:0] M26_P0 = 26'b10101010101010110101011011;
  localparam logic [25:0] M26_P1 = 26'b11001100110011011001101101;
  localparam logic [25:0] M26_P2 = 26'b11110000111100011110001110;
  localparam logic [25:0] M26_P3 = 26'b11111111000000011111110000;
  localparam logic [25:0] M26_P4 = 26'b11111111111111100000000000;

  // The widest code that fits in the output bus bounds the requested mode.
  localparam logic [1:0] MAX_MODE = (DATA_WIDTH == 8)  ? 2'd0 :
                                    (DATA_WIDTH == 16) ? 2'd1 : 2'd2;

  function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] mode);
    logic [3:0]  i4;
    logic [10:0] i11;
    logic [25:0] i26;
    logic [2:0]  p3;
    logic [3:0]  p4;
    logic [4:0]  p5;
    logic [31:0] r;
    i4  = d[3:0];
    i11 = d[10:0];
    i26 = d[25:0];
    p3[0] = ^(i4 & M4_P0);
    p3[1] = ^(i4 & M4_P1);
    p3[2] = ^(i4 & M4_P2);
    p4[0] = ^(i11 & M11_P0);
    p4[1] = ^(i11 & M11_P1);
    p4[2] = ^(i11 & M11_P2);
    p4[3] = ^(i11 & M11_P3);
    p5[0] = ^(i26 & M26_P0);
    p5[1] = ^(i26 & M26_P1);
    p5[2] = ^(i26 & M26_P2);
    p5[3] = ^(i26 & M26_P3);
    p5[4] = ^(i26 & M26_P4);
    r = '0;
    // Top parity bit covers the whole word so double errors are detectable.
    case (mode)
      2'd0:    r = {24'd0, i4, (^p3) ^ (^i4), p3};
      2'd1:    r = {16'd0, i11, (^p4) ^ (^i11), p4};
      default: r = {i26, (^p5) ^ (^i26), p5};
    endcase
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] code_q, code_d;
  logic [1:0]            mode_q, mode_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [31:0]           infoExt;
  logic [31:0]           encFull;
  logic [1:0]            effMode;
  logic                  accept;

  generate
    if (DATA_WIDTH >= 32) begin : gWide
      assign infoExt = info[31:0];
    end else begin : gNarrow
      assign infoExt = {{(32 - DATA_WIDTH){1'b0}}, info};
    end
  endgenerate

  always_comb begin
    effMode = MAX_MODE;
    if (cw_mode <= AMBA_WORD'(MAX_MODE)) begin
      effMode = cw_mode[1:0];
    end
  end

  assign encFull  = encode(infoExt, effMode);
  // clr blocks acceptance so a word arriving with it is simply dropped.
  assign in_ready = ~clr & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    code_d  = code_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (clr) begin
      code_d  = '0;
      mode_d  = 2'd0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      code_d  = encFull[DATA_WIDTH-1:0] ^ (err_inj ? err_mask : '0);
      mode_d  = effMode;
      valid_d = 1'b1;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q  <= '0;
      mode_q  <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      code_q  <= code_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign codeword  = code_q;
  assign out_mode  = mode_q;
  assign out_valid = valid_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_ecc_enc_stream.sv
// Directed bench for ecc_enc_stream: a 32-bit instance plus an 8-bit instance and a
// 2-bit-counter instance that share the same stimulus.
module tb_ecc_enc_stream;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [31:0] info;
  logic [31:0] cw_mode;
  logic [31:0] err_mask;
  logic        err_inj;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] codeword;
  logic [1:0]  out_mode;
  logic [15:0] word_cnt;

  logic        ready8, valid8;
  logic [7:0]  code8;
  logic [1:0]  mode8;
  logic [15:0] cnt8;

  logic        readyS, validS;
  logic [31:0] codeS;
  logic [1:0]  modeS;
  logic [1:0]  cntS;

  int errors = 0;
  int checks = 0;

  ecc_enc_stream #(.DATA_WIDTH(32), .AMBA_WORD(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .info(info), .cw_mode(cw_mode), .err_mask(err_mask), .err_inj(err_inj),
    .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword),
    .out_mode(out_mode), .word_cnt(word_cnt));

  ecc_enc_stream #(.DATA_WIDTH(8), .AMBA_WORD(32), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ready8),
    .info(info[7:0]), .cw_mode(cw_mode), .err_mask(err_mask[7:0]), .err_inj(err_inj),
    .out_valid(valid8), .out_ready(out_ready), .codeword(code8),
    .out_mode(mode8), .word_cnt(cnt8));

  ecc_enc_stream #(.DATA_WIDTH(32), .AMBA_WORD(32), .CNT_WIDTH(2)) dutS (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(readyS),
    .info(info), .cw_mode(cw_mode), .err_mask(err_mask), .err_inj(err_inj),
    .out_valid(validS), .out_ready(out_ready), .codeword(codeS),
    .out_mode(modeS), .word_cnt(cntS));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word: accept, check registered result, then drain and check hold.
  task automatic applyStimulus(input string tag, input logic [31:0] infoV, input logic [31:0] modeV,
                               input logic injV, input logic [31:0] maskV,
                               input logic [31:0] expCode, input logic [1:0] expMode,
                               input logic [7:0] exp8);
    in_valid  = 1'b1;
    info      = infoV;
    cw_mode   = modeV;
    err_inj   = injV;
    err_mask  = maskV;
    out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    info     = 32'hDEAD_BEEF;
    err_inj  = 1'b0;
    err_mask = 32'hFFFF_FFFF;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_code"}, codeword, expCode);
    checkOutput({tag, "_mode"}, 32'(out_mode), 32'(expMode));
    checkOutput({tag, "_code8"}, 32'(code8), 32'(exp8));
    checkOutput({tag, "_mode8"}, 32'(mode8), 32'd0);
    tick();
    checkOutput({tag, "_drain"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_hold"}, codeword, expCode);
  endtask

  logic [31:0] burstExp [8] = '{32'h1B, 32'h2D, 32'h36, 32'h4E, 32'h55, 32'h63, 32'h78, 32'h87};

  initial begin
    int sent;
    int recv;
    logic mValid;
    logic acc;

    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; info = '0; cw_mode = '0;
    err_mask = '0; err_inj = 1'b0; out_ready = 1'b1;
    #12;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_code", codeword, 32'd0);
    checkOutput("rst_mode", 32'(out_mode), 32'd0);
    checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b1;
    tick();

    applyStimulus("m0", 32'h0000_000B, 32'd0, 1'b0, 32'h0, 32'h0000_00B1, 2'd0, 8'hB1);
    applyStimulus("m1", 32'h0000_0001, 32'd1, 1'b0, 32'h0, 32'h0000_0033, 2'd1, 8'h1B);
    applyStimulus("m2", 32'h0000_0001, 32'd2, 1'b0, 32'h0, 32'h0000_0063, 2'd2, 8'h1B);
    applyStimulus("m7", 32'h0000_0001, 32'd7, 1'b0, 32'h0, 32'h0000_0063, 2'd2, 8'h1B);
    applyStimulus("inj", 32'h0000_000B, 32'd0, 1'b1, 32'h1, 32'h0000_00B0, 2'd0, 8'hB0);
    applyStimulus("msb", 32'hFFFF_FFF0, 32'd0, 1'b0, 32'h0, 32'h0000_0000, 2'd0, 8'h00);
    applyStimulus("pad", 32'h0000_000B, 32'd0, 1'b1, 32'h8000_0000, 32'h8000_00B1, 2'd0, 8'hB1);
    checkOutput("cnt7", 32'(word_cnt), 32'd7);
    checkOutput("cnt_sat", 32'(cntS), 32'd3);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_cnt", 32'(word_cnt), 32'd0);

    // Back-to-back burst with a three-cycle downstream stall.
    sent = 0; recv = 0; mValid = 1'b0;
    cw_mode = 32'd0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      in_valid  = (sent < 8);
      info      = (sent < 8) ? 32'(sent + 1) : 32'hDEAD_BEEF;
      out_ready = !(c >= 3 && c <= 5);
      #1;
      checkOutput("burst_valid", 32'(out_valid), 32'(mValid));
      checkOutput("burst_ready", 32'(in_ready), 32'(!mValid || out_ready));
      if (mValid) checkOutput("burst_code", codeword, burstExp[recv]);
      acc = in_valid && (!mValid || out_ready);
      if (mValid && out_ready) recv++;
      if (acc) begin
        sent++;
        mValid = 1'b1;
      end else if (out_ready) begin
        mValid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("burst_recv", 32'(recv), 32'd8);
    checkOutput("burst_cnt", 32'(word_cnt), 32'd8);

    // clr wins over a simultaneous accept while a word is pending.
    in_valid = 1'b1; info = 32'hB; out_ready = 1'b0;
    tick();
    checkOutput("pre_clr_valid", 32'(out_valid), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("clr_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("clr_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_cnt2", 32'(word_cnt), 32'd0);
    checkOutput("clr_code", codeword, 32'd0);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Counter saturation on the 2-bit instance.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      info = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checkOutput("sat_small", 32'(cntS), 32'd3);
    checkOutput("sat_main", 32'(word_cnt), 32'd5);

    // Asynchronous reset in the middle of a stall.
    in_valid = 1'b1; info = 32'hB; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_code", codeword, 32'd0);
    checkOutput("arst_cnt", 32'(word_cnt), 32'd0);
    #2;
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
